// File: rtl/i2s_sched_pkg.sv
// +------------------------------------------------------------------+
// | i2s_sched_pkg : state and channel-mode encodings for i2s_tx_sched |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package i2s_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_L = 2'd1,
    WAIT_R = 2'd2,
    DUP    = 2'd3
  } sched_state_e;

  typedef enum logic [1:0] {
    STEREO = 2'b00,
    MONO_L = 2'b01,
    MONO_R = 2'b10,
    DUP_L  = 2'b11
  } chm_e;

  // A frame opens on the right channel only for right-mono.
  function automatic sched_state_e start_state(input chm_e m);
    return (m == MONO_R) ? WAIT_R : WAIT_L;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_sched_cells.sv
// +------------------------------------------------------------------+
// | dffr / dffer : reset and reset+enable flop cells                 |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module dffr #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) q_o <= RST_VAL;
    else          q_o <= d_i;
  end
endmodule

module dffer #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  always_ff @(posedge clk_i) begin
    if (!rst_n_i)  q_o <= RST_VAL;
    else if (en_i) q_o <= d_i;
  end
endmodule

`default_nettype wire

// File: rtl/i2s_tx_sched.sv
// +------------------------------------------------------------------+
// | i2s_tx_sched : orders left/right samples into the I2S TX FIFO     |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module i2s_tx_sched
  import i2s_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TMO_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  flush_i,
  input  logic [1:0]            chm_i,
  input  logic [TMO_WIDTH-1:0]  tmo_i,
  input  logic                  l_valid_i,
  output logic                  l_ready_o,
  input  logic [DATA_WIDTH-1:0] l_data_i,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  output logic                  fifo_push_o,
  output logic [DATA_WIDTH-1:0] fifo_dat_o,
  input  logic                  fifo_full_i,
  output logic                  busy_o,
  output logic                  undr_o,
  output logic [15:0]           frm_cnt_o
);

  logic [1:0]            state_raw_q;
  logic [1:0]            mode_raw_q;
  sched_state_e          state_q, state_d;
  chm_e                  mode_q, chm_in;
  logic                  mode_en;
  logic [15:0]           frm_cnt_q, frm_cnt_d;
  logic [TMO_WIDTH-1:0]  tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] held_q;
  logic                  live, l_hs, r_hs, complete;

  assign state_q = sched_state_e'(state_raw_q);
  assign mode_q  = chm_e'(mode_raw_q);
  assign chm_in  = chm_e'(chm_i);

  // Readies and pushes are suppressed during a flush or reset cycle.
  assign live      = rst_n_i & ~flush_i;
  assign l_ready_o = live & (state_q == WAIT_L) & ~fifo_full_i;
  assign r_ready_o = live & (state_q == WAIT_R) & ~fifo_full_i;
  assign l_hs      = l_ready_o & l_valid_i;
  assign r_hs      = r_ready_o & r_valid_i;
  assign busy_o    = rst_n_i & (((state_q == WAIT_R) && (mode_q == STEREO)) || (state_q == DUP));
  assign frm_cnt_o = frm_cnt_q;

  always_comb begin
    state_d     = state_q;
    mode_en     = 1'b0;
    frm_cnt_d   = frm_cnt_q;
    tmo_d       = '0;
    fifo_push_o = 1'b0;
    fifo_dat_o  = '0;
    undr_o      = 1'b0;
    complete    = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_i) begin
          state_d = start_state(chm_in);
          mode_en = 1'b1;
        end
      end
      WAIT_L: begin
        if (l_hs) begin
          fifo_push_o = 1'b1;
          fifo_dat_o  = l_data_i;
          case (mode_q)
            STEREO:  state_d = WAIT_R;
            DUP_L:   state_d = DUP;
            default: complete = 1'b1;
          endcase
        end else if (!en_i) begin
          state_d = IDLE;
        end
      end
      WAIT_R: begin
        if (r_hs) begin
          fifo_push_o = 1'b1;
          fifo_dat_o  = r_data_i;
          complete    = 1'b1;
        end else if (live && (mode_q == STEREO) && (tmo_i != '0) &&
                     (tmo_q == tmo_i) && !fifo_full_i) begin
          fifo_push_o = 1'b1;
          undr_o      = 1'b1;
          complete    = 1'b1;
        end else if ((mode_q == MONO_R) && !en_i) begin
          state_d = IDLE;
        end else begin
          tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
        end
      end
      DUP: begin
        if (live && !fifo_full_i) begin
          fifo_push_o = 1'b1;
          fifo_dat_o  = held_q;
          complete    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (complete) begin
      frm_cnt_d = frm_cnt_q + 16'd1;
      mode_en   = 1'b1;
      state_d   = en_i ? start_state(chm_in) : IDLE;
    end

    if (flush_i) begin
      state_d   = IDLE;
      mode_en   = 1'b0;
      frm_cnt_d = '0;
      tmo_d     = '0;
    end
  end

  dffr #(.W(2), .RST_VAL(2'(IDLE))) u_state (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(state_d), .q_o(state_raw_q)
  );

  dffer #(.W(2), .RST_VAL(2'(STEREO))) u_mode (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(mode_en), .d_i(chm_i), .q_o(mode_raw_q)
  );

  dffr #(.W(16), .RST_VAL(16'd0)) u_frm_cnt (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(frm_cnt_d), .q_o(frm_cnt_q)
  );

  dffr #(.W(TMO_WIDTH), .RST_VAL('0)) u_tmo (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(tmo_d), .q_o(tmo_q)
  );

  dffer #(.W(DATA_WIDTH), .RST_VAL('0)) u_held (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(l_hs), .d_i(l_data_i), .q_o(held_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_sched.sv
// +------------------------------------------------------------------+
// | tb_i2s_tx_sched : directed vector bench for i2s_tx_sched          |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_i2s_tx_sched;

  logic        clk = 1'b0;
  logic        rst_n, en, flush, lv, rv, full;
  logic [1:0]  chm;
  logic [7:0]  tmo;
  logic [31:0] ld, rd;
  logic        lr, rr, push, busy, undr;
  logic [31:0] dat;
  logic [15:0] cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst_n, en, flush;
    logic [1:0]  chm;
    logic [7:0]  tmo;
    logic        lv;
    logic [31:0] ld;
    logic        rv;
    logic [31:0] rd;
    logic        full;
    logic        e_lr, e_rr, e_push;
    logic [31:0] e_dat;
    logic        e_busy, e_undr;
    logic [15:0] e_cnt;
  } vec_t;

  i2s_tx_sched #(.DATA_WIDTH(32), .TMO_WIDTH(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .flush_i(flush), .chm_i(chm), .tmo_i(tmo),
    .l_valid_i(lv), .l_ready_o(lr), .l_data_i(ld),
    .r_valid_i(rv), .r_ready_o(rr), .r_data_i(rd),
    .fifo_push_o(push), .fifo_dat_o(dat), .fifo_full_i(full),
    .busy_o(busy), .undr_o(undr), .frm_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t nv(
    input logic r, e, f, input logic [1:0] c, input logic [7:0] t,
    input logic l_v, input logic [31:0] l_d, input logic r_v, input logic [31:0] r_d,
    input logic fu, input logic xlr, xrr, xpush, input logic [31:0] xdat,
    input logic xbusy, xundr, input logic [15:0] xcnt);
    vec_t v;
    v.rst_n = r; v.en = e; v.flush = f; v.chm = c; v.tmo = t;
    v.lv = l_v; v.ld = l_d; v.rv = r_v; v.rd = r_d; v.full = fu;
    v.e_lr = xlr; v.e_rr = xrr; v.e_push = xpush; v.e_dat = xdat;
    v.e_busy = xbusy; v.e_undr = xundr; v.e_cnt = xcnt;
    return v;
  endfunction

  task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string tag);
    rst_n = v.rst_n; en = v.en; flush = v.flush; chm = v.chm; tmo = v.tmo;
    lv = v.lv; ld = v.ld; rv = v.rv; rd = v.rd; full = v.full;
    @(negedge clk);
    chk(tag, "l_ready", 32'(lr), 32'(v.e_lr));
    chk(tag, "r_ready", 32'(rr), 32'(v.e_rr));
    chk(tag, "push", 32'(push), 32'(v.e_push));
    if (v.e_push) chk(tag, "dat", dat, v.e_dat);
    chk(tag, "busy", 32'(busy), 32'(v.e_busy));
    chk(tag, "undr", 32'(undr), 32'(v.e_undr));
    chk(tag, "frm_cnt", 32'(cnt), 32'(v.e_cnt));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; chm = 2'b00; tmo = 8'd0;
    lv = 1'b0; ld = '0; rv = 1'b0; rd = '0; full = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[23];

  initial begin
    // Stereo frames, then en_i dropped in an idle start state
    tbl[0]  = nv(0,0,0,2'b00,0, 0,0,    0,0,    0, 0,0,0,0,    0,0,0);
    tbl[1]  = nv(1,1,0,2'b00,0, 1,'h11, 1,'h22, 0, 0,0,0,0,    0,0,0);
    tbl[2]  = nv(1,1,0,2'b00,0, 1,'h11, 1,'h22, 0, 1,0,1,'h11, 0,0,0);
    tbl[3]  = nv(1,1,0,2'b00,0, 1,'h11, 1,'h22, 0, 0,1,1,'h22, 1,0,0);
    tbl[4]  = nv(1,1,0,2'b00,0, 1,'h33, 1,'h44, 0, 1,0,1,'h33, 0,0,1);
    tbl[5]  = nv(1,1,0,2'b00,0, 1,'h33, 1,'h44, 0, 0,1,1,'h44, 1,0,1);
    tbl[6]  = nv(1,1,0,2'b00,0, 0,0,    0,0,    0, 1,0,0,0,    0,0,2);
    tbl[7]  = nv(1,0,0,2'b00,0, 0,0,    0,0,    0, 1,0,0,0,    0,0,2);
    tbl[8]  = nv(1,0,0,2'b00,0, 0,0,    0,0,    0, 0,0,0,0,    0,0,2);
    // Duplicate-left frame
    tbl[9]  = nv(0,0,0,2'b00,0, 0,0,    0,0,    0, 0,0,0,0,    0,0,2);
    tbl[10] = nv(1,1,0,2'b11,0, 1,'hA5, 1,'h22, 0, 0,0,0,0,    0,0,0);
    tbl[11] = nv(1,1,0,2'b11,0, 1,'hA5, 1,'h22, 0, 1,0,1,'hA5, 0,0,0);
    tbl[12] = nv(1,0,0,2'b11,0, 0,0,    1,'h22, 0, 0,0,1,'hA5, 1,0,0);
    tbl[13] = nv(1,0,0,2'b11,0, 0,0,    1,'h22, 0, 0,0,0,0,    0,0,1);
    // Right-sample timeout: zero pushed 4 cycles after WAIT_R entry
    tbl[14] = nv(0,0,0,2'b00,4, 0,0,    0,0,    0, 0,0,0,0,    0,0,1);
    tbl[15] = nv(1,1,0,2'b00,4, 1,'h55, 0,0,    0, 0,0,0,0,    0,0,0);
    tbl[16] = nv(1,1,0,2'b00,4, 1,'h55, 0,0,    0, 1,0,1,'h55, 0,0,0);
    tbl[17] = nv(1,1,0,2'b00,4, 0,0,    0,0,    0, 0,1,0,0,    1,0,0);
    tbl[18] = nv(1,1,0,2'b00,4, 0,0,    0,0,    0, 0,1,0,0,    1,0,0);
    tbl[19] = nv(1,1,0,2'b00,4, 0,0,    0,0,    0, 0,1,0,0,    1,0,0);
    tbl[20] = nv(1,1,0,2'b00,4, 0,0,    0,0,    0, 0,1,0,0,    1,0,0);
    tbl[21] = nv(1,0,0,2'b00,4, 0,0,    0,0,    0, 0,1,1,0,    1,1,0);
    tbl[22] = nv(1,0,0,2'b00,4, 0,0,    0,0,    0, 0,0,0,0,    0,0,1);

    do_reset();
    do_reset();
    for (int i = 0; i < 23; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Backpressure: full in WAIT_L blocks the handshake, full in DUP holds
    do_reset();
    apply(nv(1,1,0,2'b11,0, 1,'hC3, 0,0, 0, 0,0,0,0, 0,0,0), "bp_idle");
    apply(nv(1,1,0,2'b11,0, 1,'hC3, 0,0, 1, 0,0,0,0, 0,0,0), "bp_wl_full");
    apply(nv(1,1,0,2'b11,0, 1,'hC3, 0,0, 0, 1,0,1,'hC3, 0,0,0), "bp_wl");
    for (int k = 0; k < 5; k++)
      apply(nv(1,1,0,2'b11,0, 0,0, 0,0, 1, 0,0,0,0, 1,0,0), $sformatf("bp_dup_full%0d", k));
    apply(nv(1,0,0,2'b11,0, 0,0, 0,0, 0, 0,0,1,'hC3, 1,0,0), "bp_dup_go");
    apply(nv(1,0,0,2'b11,0, 0,0, 0,0, 0, 0,0,0,0, 0,0,1), "bp_after");

    // Mode change mid-frame: right still pushed, next frame opens in WAIT_R
    do_reset();
    apply(nv(1,1,0,2'b00,0, 1,'h61, 0,0,    0, 0,0,0,0,    0,0,0), "mc_idle");
    apply(nv(1,1,0,2'b00,0, 1,'h61, 0,0,    0, 1,0,1,'h61, 0,0,0), "mc_left");
    apply(nv(1,1,0,2'b10,0, 1,'h61, 1,'h62, 0, 0,1,1,'h62, 1,0,0), "mc_right");
    apply(nv(1,1,0,2'b10,0, 1,'h61, 1,'h63, 0, 0,1,1,'h63, 0,0,1), "mc_monor");
    apply(nv(1,0,0,2'b10,0, 1,'h61, 0,0,    0, 0,1,0,0,    0,0,2), "mc_stop");
    apply(nv(1,0,0,2'b10,0, 1,'h61, 1,'h64, 0, 0,0,0,0,    0,0,2), "mc_idle2");

    // Flush, then reset, each asserted in WAIT_R with frm_cnt at 7
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      apply(nv(1,1,0,2'b00,0, 1,'h70, 1,'h80, 0, 0,0,0,0, 0,0,0), "fr_idle");
      for (int k = 0; k < 7; k++) begin
        apply(nv(1,1,0,2'b00,0, 1,32'h100+k, 1,32'h200+k, 0, 1,0,1,32'h100+k, 0,0,16'(k)), "fr_l");
        apply(nv(1,1,0,2'b00,0, 1,32'h100+k, 1,32'h200+k, 0, 0,1,1,32'h200+k, 1,0,16'(k)), "fr_r");
      end
      apply(nv(1,1,0,2'b00,0, 1,'h1F, 0,0, 0, 1,0,1,'h1F, 0,0,7), "fr_l7");
      apply(nv(1,1,0,2'b00,0, 0,0,    0,0, 0, 0,1,0,0,    1,0,7), "fr_wr");
      if (pass == 0)
        apply(nv(1,1,1,2'b00,0, 1,'h1E, 1,'h2E, 0, 0,0,0,0, 1,0,7), "fr_flush");
      else
        apply(nv(0,1,0,2'b00,0, 1,'h1E, 1,'h2E, 0, 0,0,0,0, 0,0,7), "fr_rst");
      apply(nv(1,0,0,2'b00,0, 1,'h1E, 1,'h2E, 0, 0,0,0,0, 0,0,0), "fr_after");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
